// File: rtl/dmem_responder_pkg.sv
// Shared ISA package: memory access encodings, responder FSM states and the
// alignment check used by the data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_access_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // Any encoding outside the three access types is rejected as an error.
    function automatic logic access_err(mem_access_type_e access, logic [1:0] lane);
        case (access)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return lane[0];
            MEM_WORD: return (lane != 2'b00);
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// LSU <-> data-memory request/response bus. The core drives the master side,
// the responder implements the slave side.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    mem_access_type_e req_access;
    logic             req_unsigned;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_access, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_access, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store mask/data replication and
// load lane extraction with sign or zero extension. Purely combinational.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  mem_access_type_e access_i,
    input  logic [1:0]       lane_i,
    input  logic             unsigned_i,
    input  logic [31:0]      wdata_i,
    input  logic [31:0]      rword_i,
    output logic [3:0]       wmask_o,
    output logic [31:0]      wdata_o,
    output logic [31:0]      rdata_o
);

    logic [31:0] rshift;

    assign rshift = rword_i >> {lane_i, 3'b000};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rword_i;
        case (access_i)
            MEM_BYTE: begin
                wmask_o = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'b0, rshift[7:0]}
                                     : {{24{rshift[7]}}, rshift[7:0]};
            end
            MEM_HALF: begin
                wmask_o = 4'b0011 << {lane_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'b0, rshift[15:0]}
                                     : {{16{rshift[15]}}, rshift[15:0]};
            end
            MEM_WORD: wmask_o = 4'b1111;
            default:  ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised storage behind a single-outstanding
// request/response handshake. Optional wait states with `DMEM_WAIT_STATES_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (WAIT_STATES > 15 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_err
        $error("dmem_responder: DEPTH must be a power of two and WAIT_STATES <= 15");
    end

    dmem_state_e      state_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic             write_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    mem_access_type_e access_q;
    logic             unsigned_q;
`ifdef DMEM_WAIT_STATES_EN
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    logic [3:0]       cnt_q;
`endif

    logic             cur_write;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    mem_access_type_e cur_access;
    logic             cur_unsigned;
    logic             cur_err;
    logic             enter_resp;
    logic             store_fire;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       wmask;
    logic [31:0]      wdata_al;
    logic [31:0]      load_data;
    logic [31:0]      rsp_rdata_d;
    logic [31:0]      mem_q [DEPTH];

    // Without wait states the access completes on the acceptance edge, so the
    // live request is used in IDLE and the latched copy afterwards.
    always_comb begin
        cur_write    = write_q;
        cur_addr     = addr_q;
        cur_wdata    = wdata_q;
        cur_access   = access_q;
        cur_unsigned = unsigned_q;
        if (state_q == IDLE) begin
            cur_write    = bus.req_write;
            cur_addr     = bus.req_addr;
            cur_wdata    = bus.req_wdata;
            cur_access   = bus.req_access;
            cur_unsigned = bus.req_unsigned;
        end
    end

    always_comb begin
        enter_resp = 1'b0;
        case (state_q)
`ifdef DMEM_WAIT_STATES_EN
            IDLE:    enter_resp = bus.req_valid && (WAIT_INIT == 4'd0);
            BUSY:    enter_resp = (cnt_q == 4'd1);
`else
            IDLE:    enter_resp = bus.req_valid;
`endif
            default: enter_resp = 1'b0;
        endcase
    end

    assign word_idx    = cur_addr[IDX_W+1:2];
    assign cur_err     = access_err(cur_access, cur_addr[1:0]) || (|cur_addr[31:IDX_W+2]);
    assign store_fire  = rst_n && enter_resp && cur_write && !cur_err;
    assign rsp_rdata_d = (cur_write || cur_err) ? 32'h0 : load_data;

    dmem_lane_align u_lane_align (
        .access_i   (cur_access),
        .lane_i     (cur_addr[1:0]),
        .unsigned_i (cur_unsigned),
        .wdata_i    (cur_wdata),
        .rword_i    (mem_q[word_idx]),
        .wmask_o    (wmask),
        .wdata_o    (wdata_al),
        .rdata_o    (load_data)
    );

    // NOTE: storage has no reset branch so it maps onto RAM; contents start undefined.
    always_ff @(posedge clk) begin
        if (store_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem_q[word_idx][8*b +: 8] <= wdata_al[8*b +: 8];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            access_q    <= MEM_BYTE;
            unsigned_q  <= 1'b0;
`ifdef DMEM_WAIT_STATES_EN
            cnt_q       <= 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        access_q    <= bus.req_access;
                        unsigned_q  <= bus.req_unsigned;
                        req_ready_q <= 1'b0;
`ifdef DMEM_WAIT_STATES_EN
                        cnt_q       <= WAIT_INIT;
                        state_q     <= (WAIT_INIT != 4'd0) ? BUSY : RESP;
`else
                        state_q     <= RESP;
`endif
                    end
                end
`ifdef DMEM_WAIT_STATES_EN
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= RESP;
                end
`endif
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= cur_err;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued when a
// request is driven and compared when the response appears.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 3;
`ifdef DMEM_WAIT_STATES_EN
    localparam int EXP_LAT = 1 + WS;
`else
    localparam int EXP_LAT = 1;
`endif
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    rsp_t exp_q[$];

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] acc, input logic uns,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int hold, input string name);
        rsp_t want, got;
        int   lat, tmo;
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_access   = mem_access_type_e'(acc);
        bus.req_unsigned = uns;
        bus.rsp_ready    = (hold == 0);
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        tmo = 0;
        while (bus.req_ready !== 1'b1 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        if (bus.req_ready !== 1'b1) begin
            n_cmp++; n_mis++;
            $display("FAIL %s accept: req_ready=%b required 1", name, bus.req_ready);
        end
        @(negedge clk);
        acc_cyc = cyc;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== EXP_LAT) begin
            n_mis++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, EXP_LAT);
        end
        want = exp_q.pop_front();
        got  = {bus.rsp_rdata, bus.rsp_err};
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s rsp: rdata=%h err=%b required rdata=%h err=%b",
                     name, got.rdata, got.err, want.rdata, want.err);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                {bus.rsp_rdata, bus.rsp_err} !== want) begin
                n_mis++;
                $display("FAIL %s hold[%0d]: valid=%b ready=%b rdata=%h required 1 0 %h",
                         name, i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata, want.rdata);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL %s post: rsp_valid=%b req_ready=%b required 0 1",
                     name, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            n_mis++;
            $display("FAIL %s: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     name, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_word();
        access(1, 32'h10, 32'hDEADBEEF, W, 0, 32'h0, 0, 0, "sw_10");
        access(0, 32'h10, 32'h0, W, 0, 32'hDEADBEEF, 0, 0, "lw_10");
    endtask

    task automatic test_byte();
        access(1, 32'h13, 32'h5A5A5A80, B, 0, 32'h0, 0, 0, "sb_13");
        access(0, 32'h13, 32'h0, B, 0, 32'hFFFFFF80, 0, 0, "lb_13");
        access(0, 32'h13, 32'h0, B, 1, 32'h00000080, 0, 0, "lbu_13");
        access(0, 32'h10, 32'h0, W, 0, 32'h80ADBEEF, 0, 0, "lw_10_after_sb");
        access(0, 32'h11, 32'h0, B, 0, 32'hFFFFFFBE, 0, 0, "lb_11");
        access(0, 32'h12, 32'h0, B, 1, 32'h000000AD, 0, 0, "lbu_12");
    endtask

    task automatic test_half();
        access(1, 32'h14, 32'h0BADF00D, W, 0, 32'h0, 0, 0, "sw_14");
        access(1, 32'h16, 32'h77778001, H, 0, 32'h0, 0, 0, "sh_16");
        access(0, 32'h16, 32'h0, H, 0, 32'hFFFF8001, 0, 0, "lh_16");
        access(0, 32'h16, 32'h0, H, 1, 32'h00008001, 0, 0, "lhu_16");
        access(0, 32'h14, 32'h0, W, 0, 32'h8001F00D, 0, 0, "lw_14");
        access(0, 32'h14, 32'h0, H, 0, 32'hFFFFF00D, 0, 0, "lh_14");
        access(1, 32'h20, 32'h11223344, W, 0, 32'h0, 0, 0, "sw_20");
        access(0, 32'h22, 32'h0, H, 0, 32'h00001122, 0, 0, "lh_22");
        access(0, 32'h21, 32'h0, B, 0, 32'h00000033, 0, 0, "lb_21");
    endtask

    task automatic test_errors();
        access(0, 32'h12, 32'h0, W, 0, 32'h0, 1, 0, "lw_misaligned");
        access(1, 32'h21, 32'h0000BEEF, H, 0, 32'h0, 1, 0, "sh_misaligned");
        access(1, 32'h22, 32'hFFFFFFFF, W, 0, 32'h0, 1, 0, "sw_misaligned");
        access(1, 32'h20, 32'hFFFFFFFF, X, 0, 32'h0, 1, 0, "store_type_11");
        access(0, 32'h20, 32'h0, X, 0, 32'h0, 1, 0, "load_type_11");
        access(0, 32'h23, 32'h0, H, 0, 32'h0, 1, 0, "lh_misaligned");
        access(0, 32'h20, 32'h0, W, 0, 32'h11223344, 0, 0, "lw_20_unchanged");
    endtask

    task automatic test_range();
        access(1, 32'h0, 32'h01020304, W, 0, 32'h0, 0, 0, "sw_0");
        access(1, DEPTH*4 - 4, 32'hCAFEF00D, W, 0, 32'h0, 0, 0, "sw_last");
        access(0, DEPTH*4 - 4, 32'h0, W, 0, 32'hCAFEF00D, 0, 0, "lw_last");
        access(1, DEPTH*4, 32'hFFFFFFFF, W, 0, 32'h0, 1, 0, "sw_oob");
        access(0, DEPTH*4, 32'h0, W, 0, 32'h0, 1, 0, "lw_oob");
        access(1, 32'hFFFFFFFC, 32'hFFFFFFFF, W, 0, 32'h0, 1, 0, "sw_top");
        access(0, 32'h0, 32'h0, W, 0, 32'h01020304, 0, 0, "lw_0_unaliased");
        access(0, DEPTH*4 - 4, 32'h0, W, 0, 32'hCAFEF00D, 0, 0, "lw_last_unaliased");
    endtask

    task automatic test_hold();
        access(0, 32'h10, 32'h0, W, 0, 32'h80ADBEEF, 0, 5, "lw_hold");
    endtask

    task automatic test_back_to_back();
        int first;
        access(0, 32'h10, 32'h0, W, 0, 32'h80ADBEEF, 0, 0, "b2b_a");
        first = acc_cyc;
        access(0, 32'h14, 32'h0, W, 0, 32'h8001F00D, 0, 0, "b2b_b");
        n_cmp++;
        if (acc_cyc - first !== 1 + EXP_LAT) begin
            n_mis++;
            $display("FAIL b2b period: got %0d required %0d", acc_cyc - first, 1 + EXP_LAT);
        end
    endtask

    // With wait states the store is aborted in BUSY; otherwise a load is aborted in RESP.
    task automatic test_reset_mid();
        logic wr;
`ifdef DMEM_WAIT_STATES_EN
        wr = 1'b1;
`else
        wr = 1'b0;
`endif
        access(1, 32'h40, 32'hA5A5A5A5, W, 0, 32'h0, 0, 0, "sw_40_old");
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'h12345678;
        bus.req_access = MEM_WORD;
        bus.rsp_ready  = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_async");
        @(negedge clk);
        check_reset_outputs("reset_mid_held");
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        access(0, 32'h40, 32'h0, W, 0, 32'hA5A5A5A5, 0, 0, "lw_40_after_reset");
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_access   = MEM_WORD;
        bus.req_unsigned = 1'b0;
        bus.rsp_ready    = 1'b1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_range();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

- Data-memory responder: the memory end of the core's load/store request/response interface.
- Accepts one byte, halfword or word access per handshake from the core's LSU, using `mem_access_type_e`.
- Performs byte-lane steering and write masking into a word-organised storage array.
- Returns sign- or zero-extended load data, or an error flag for misaligned/out-of-range accesses, after an optional programmable wait-state delay.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words of storage; power of two.
- `WAIT_STATES`, 0: extra cycles between acceptance and response; 0..15. Only used with `DMEM_WAIT_STATES_EN`.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_access` input 2: `mem_access_type_e`.
- `req_unsigned` input 1: load zero-extends (LBU/LHU); ignored for word accesses and stores.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: core accepts the response.
- `rsp_rdata` output 32: extended load data; 0 for stores and on error.
- `rsp_err` output 1: misaligned, invalid access type, or out of range.

## Operation
- FSM `dmem_state_e`: IDLE, BUSY, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch all request fields.
  - Go to BUSY if the effective wait count is >0, else RESP.
- BUSY:
  - Count the wait cycles down.
  - Go to RESP on the edge where the counter reaches 0.
- RESP:
  - `rsp_valid`=1.
  - Hold `rsp_rdata`/`rsp_err` stable until `rsp_ready`.
  - Return to IDLE on the handshake edge.
- Word index is `addr[log2(DEPTH)+1:2]`; byte lane is `addr[1:0]`.
- Error conditions:
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - `req_access`=2'b11.
  - `addr[31:2]` ≥ `DEPTH`.
  - On error: no write, `rdata`=0, `err`=1.
- Store lane writes:
  - Byte: `wdata[7:0]` to lane `addr[1:0]`.
  - Half: `wdata[15:0]` to lanes {`addr[1]`,0}/{`addr[1]`,1}.
  - Word: all four lanes.
  - Other lanes are unchanged.
- Store commit happens on the edge that enters RESP; read data is sampled on the same edge.
- Load extension:
  - Byte/half are sign-extended from bit 7/15 unless `req_unsigned`, in which case they are zero-extended.
  - Word is returned as-is.
- Storage is not reset; contents are undefined until written.

## Timing
- Reset values:
  - `req_ready`=1 (state IDLE).
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - Wait counter = 0.
- Latency from the acceptance edge to `rsp_valid` high is 1 + effective `WAIT_STATES` cycles.
- Without the macro, latency is exactly 1.
- `req_ready` is low throughout BUSY and RESP, so at most one outstanding request.
- No request/response overlap in the same cycle: a new request is accepted no earlier than the cycle after the response handshake.
- Throughput is one access per 2 + `WAIT_STATES` cycles when `rsp_ready` is held high.
- `rsp_ready` low in RESP: outputs are held indefinitely and no state change occurs.
- Reset asserted mid-operation: return to IDLE immediately and drop the pending request. A store not yet committed (still in BUSY) is never written.
- Read-after-write: a load accepted after a store's response observes the stored data.

## Configuration
- Macro: `DMEM_WAIT_STATES_EN`.
- Defined:
  - BUSY state and the 4-bit wait counter are built.
  - `WAIT_STATES` sets the delay.
- Undefined:
  - BUSY and the counter are not compiled.
  - `WAIT_STATES` is ignored.
  - FSM goes IDLE→RESP directly, with fixed 1-cycle latency.

## Structure
- Added to the shared ISA package:
  - `dmem_state_e` (IDLE=2'b00, BUSY=2'b01, RESP=2'b10).
  - Existing `mem_access_type_e` is reused; no new access codes.
- Sub-module `dmem_lane_align`, purely combinational:
  - Store side: write-byte-mask and lane-shifted write data.
  - Load side: lane extraction and sign/zero extension.
  - Top keeps the FSM, counter, storage, and error check.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → `rdata`=0xDEADBEEF, `err`=0, latency 1 (macro off).
- SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80ADBEEF.
- SH 0x8001 @0x16, then LH → 0xFFFF8001; LHU → 0x00008001; LW @0x14 → 0x8001xxxx with the low half unchanged.
- Misalignment and invalid type:
  - LW @0x12 → `err`=1, `rdata`=0.
  - SH @0x21 → `err`=1, and a later LW @0x20 shows the word unchanged.
  - `req_access`=2'b11 → `err`=1.
- Macro on, `WAIT_STATES`=3:
  - `rsp_valid` rises 4 cycles after acceptance.
  - Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rdata` stable and `req_ready`=0.
- Reset and range:
  - Pull `rst_n` low in BUSY during SW 0x12345678 @0x40 → outputs return to reset values; a later LW @0x40 returns the old value.
  - Access at addr = DEPTH*4 → `err`=1.
